// File: rtl/easy_fifo_stream_adapter_if.sv
// easy_fifo_stream_adapter_if: FIFO read port plus valid/ready stream seen by the adapter
interface easy_fifo_stream_adapter_if #(
    parameter int DWIDTH       = 32,
    parameter int READ_LATENCY = 1
);
    localparam int CW = $clog2(READ_LATENCY + 2);
    logic              fifo_rd_en;
    logic [DWIDTH-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic [DWIDTH-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [CW-1:0]     buf_count;
    modport master (
        output fifo_rd_en, m_data, m_valid, buf_count,
        input  fifo_rd_data, fifo_rd_empty, m_ready
    );
    modport slave (
        input  fifo_rd_en, m_data, m_valid, buf_count,
        output fifo_rd_data, fifo_rd_empty, m_ready
    );
endinterface

// File: rtl/easy_fifo_stream_adapter.sv
// easy_fifo_stream_adapter: turns a fixed-latency FIFO read port into a bubble-free valid/ready stream
module easy_fifo_stream_adapter #(
    parameter int DWIDTH       = 32,
    parameter int READ_LATENCY = 1
) (
    input logic                          clk,
    input logic                          rst,
    easy_fifo_stream_adapter_if.master   bus
);
    localparam int D  = READ_LATENCY + 1;
    localparam int CW = $clog2(D + 1);
    localparam int PW = $clog2(D);

    logic [DWIDTH-1:0]       r_buf [D];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_occ;
    logic [CW-1:0]           r_inflight;
    logic [READ_LATENCY-1:0] r_issue_sr;
    logic                    w_pop;
    logic                    w_arrive;
    logic                    w_rd_en;

    assign w_pop    = (r_occ != '0) & bus.m_ready;
    assign w_arrive = r_issue_sr[READ_LATENCY-1];
    // Counting the word leaving this cycle lets a read issue every clock while streaming
    assign w_rd_en  = !rst & !bus.fifo_rd_empty & ((r_occ + r_inflight - CW'(w_pop)) < CW'(D));

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = r_occ != '0;
    assign bus.m_data     = r_buf[r_rd_ptr];
    assign bus.buf_count  = r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) r_buf[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_inflight <= '0;
            r_issue_sr <= '0;
        end else begin
            r_issue_sr <= (r_issue_sr << 1) | READ_LATENCY'(w_rd_en);
            r_occ      <= r_occ + CW'(w_arrive) - CW'(w_pop);
            r_inflight <= r_inflight + CW'(w_rd_en) - CW'(w_arrive);
            if (w_arrive) begin
                r_buf[r_wr_ptr] <= bus.fifo_rd_data;
                r_wr_ptr        <= (r_wr_ptr == PW'(D - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= (r_rd_ptr == PW'(D - 1)) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) (int'(r_occ) + int'(r_inflight)) <= D);
endmodule

// File: tb/tb_easy_fifo_stream_adapter.sv
// tb_easy_fifo_stream_adapter: scoreboard bench driving two adapters (read latency 1 and 2) from FIFO models
module tb_easy_fifo_stream_adapter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wr_en = '0;
    logic [1:0]  m_ready = '0;
    logic [31:0] wr_data [2];
    logic [31:0] mem [2][64];
    logic [5:0]  wp [2];
    logic [5:0]  rp [2];
    logic [31:0] d1 [2];
    logic [31:0] d2 [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    easy_fifo_stream_adapter_if #(.DWIDTH(32), .READ_LATENCY(1)) if0 ();
    easy_fifo_stream_adapter_if #(.DWIDTH(32), .READ_LATENCY(2)) if1 ();

    easy_fifo_stream_adapter #(.DWIDTH(32), .READ_LATENCY(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    easy_fifo_stream_adapter #(.DWIDTH(32), .READ_LATENCY(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    assign if0.fifo_rd_empty = (wp[0] == rp[0]);
    assign if1.fifo_rd_empty = (wp[1] == rp[1]);
    assign if0.fifo_rd_data  = d1[0];
    assign if1.fifo_rd_data  = d2[1];
    assign if0.m_ready       = m_ready[0];
    assign if1.m_ready       = m_ready[1];

    // Synchronous FIFO models; lane 1 adds an output register for a read latency of 2
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 2; l++) begin
                wp[l] <= '0;
                rp[l] <= '0;
                d1[l] <= '0;
                d2[l] <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (wr_en[l]) begin
                    mem[l][wp[l]] <= wr_data[l];
                    wp[l]         <= wp[l] + 1'b1;
                end
                if (l == 0 ? if0.fifo_rd_en : if1.fifo_rd_en) begin
                    d1[l] <= mem[l][rp[l]];
                    rp[l] <= rp[l] + 1'b1;
                end
                d2[l] <= d1[l];
            end
        end
    end

    function automatic logic mvalid(input int l);
        return l != 0 ? if1.m_valid : if0.m_valid;
    endfunction
    function automatic logic [31:0] mdata(input int l);
        return l != 0 ? if1.m_data : if0.m_data;
    endfunction
    function automatic logic rden(input int l);
        return l != 0 ? if1.fifo_rd_en : if0.fifo_rd_en;
    endfunction
    function automatic logic empty(input int l);
        return l != 0 ? if1.fifo_rd_empty : if0.fifo_rd_empty;
    endfunction
    function automatic logic [1:0] bcount(input int l);
        return l != 0 ? if1.buf_count : if0.buf_count;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic write_words(input int l, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en[l]   = 1'b1;
            wr_data[l] = base + 32'(i);
            if (l != 0) q1.push_back(base + 32'(i));
            else q0.push_back(base + 32'(i));
            @(posedge clk);
            #1;
        end
        wr_en[l] = 1'b0;
    endtask

    task automatic drain(input int l, input int n, input bit tog, output int first, output int last,
                         output int nv, output int viol);
        int got;
        int cyc;
        logic [31:0] e;
        got = 0;
        cyc = 0;
        first = -1;
        last = -1;
        nv = 0;
        viol = 0;
        while (got < n && cyc < 300) begin
            @(negedge clk);
            if (mvalid(l)) nv++;
            if (rden(l) && empty(l)) viol++;
            if (mvalid(l) && m_ready[l]) begin
                if (l != 0) e = (q1.size() != 0) ? q1.pop_front() : 32'hDEAD_BEEF;
                else e = (q0.size() != 0) ? q0.pop_front() : 32'hDEAD_BEEF;
                check("stream_data", mdata(l), e);
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            @(posedge clk);
            #1;
            if (tog) m_ready[l] = ~m_ready[l];
            cyc++;
        end
        check("drain_count", 32'(got), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int first, last, nv, viol, extra;
        logic [5:0] rp_start;
        logic acc_en, acc_v, acc_c;
        logic [31:0] acc_d;
        bit found;
        acc_en = 0;
        acc_v = 0;
        acc_c = 0;
        acc_d = '0;
        m_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            acc_en |= rden(0) | rden(1);
            acc_v  |= mvalid(0) | mvalid(1);
            acc_d  |= mdata(0) | mdata(1);
            acc_c  |= |(bcount(0) | bcount(1));
        end
        check("idle_rd_en", 32'(acc_en), 0);
        check("idle_valid", 32'(acc_v), 0);
        check("idle_data", acc_d, 0);
        check("idle_count", 32'(acc_c), 0);
        @(posedge clk);
        #1;

        fork
            write_words(0, 8, 32'h10);
            drain(0, 8, 1'b0, first, last, nv, viol);
        join
        check("burst_no_gap", 32'(last - first), 7);
        check("burst_rd_empty", 32'(viol), 0);

        m_ready[0] = 1'b0;
        rp_start = rp[0];
        write_words(0, 5, 32'h10);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_reads", 32'(rp[0] - rp_start), 2);
        check("bp_count", 32'(bcount(0)), 2);
        check("bp_data", mdata(0), 32'h10);
        check("bp_rd_en", 32'(rden(0)), 0);
        @(posedge clk);
        #1;
        m_ready[0] = 1'b1;
        drain(0, 5, 1'b0, first, last, nv, viol);

        m_ready[1] = 1'b1;
        fork
            write_words(1, 20, 32'h0);
            drain(1, 20, 1'b1, first, last, nv, viol);
        join
        check("rl2_rd_empty", 32'(viol), 0);
        m_ready[1] = 1'b1;

        fork
            write_words(0, 1, 32'hAB);
            drain(0, 1, 1'b0, first, last, nv, viol);
        join
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (mvalid(0)) extra++;
            if (rden(0) && empty(0)) viol++;
        end
        check("single_valid_cycles", 32'(nv + extra), 1);
        check("single_rd_empty", 32'(viol), 0);
        @(posedge clk);
        #1;

        m_ready[1] = 1'b0;
        found = 0;
        fork
            write_words(1, 4, 32'h30);
            begin
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge clk);
                    if (bcount(1) == 2'd2) found = 1;
                end
            end
        join
        check("rst_setup_found", 32'(found), 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(mvalid(1)), 0);
        check("rst_async_count", 32'(bcount(1)), 0);
        check("rst_rd_en", 32'(rden(1)), 0);
        q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready[1] = 1'b1;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (mvalid(1)) extra++;
        end
        check("rst_no_stale", 32'(extra), 0);
        @(posedge clk);
        #1;
        fork
            write_words(1, 1, 32'h55);
            drain(1, 1, 1'b0, first, last, nv, viol);
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
